// File: rtl/bcd_scan_decoder.sv
// Registered active-low one-cold code decoder with valid/ready input, out-of-range
// error flag and counter, and an auto-scan mode that walks every line at a fixed dwell.
module bcd_scan_decoder #(
  parameter int IN_W  = 4,
  parameter int OUT_N = 10,
  parameter int DWELL = 3,
  parameter int ERR_W = 8,
  localparam int IDX_W = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             mode,
  input  logic             blank,
  output logic [OUT_N-1:0] dec_n,
  output logic             out_valid,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [IDX_W-1:0] scan_idx
);

  localparam int DW_W = $clog2(DWELL + 1);
  localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUT_N - 1);
  localparam logic [IN_W:0]    OUT_N_C  = (IN_W + 1)'(OUT_N);
  localparam logic [OUT_N-1:0] ONE      = OUT_N'(1);

  if (OUT_N > 2**IN_W || OUT_N < 1) begin : g_bad_out_n
    $error("bcd_scan_decoder: OUT_N must be in 1..2**IN_W");
  end
  if (DWELL < 1) begin : g_bad_dwell
    $error("bcd_scan_decoder: DWELL must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SCAN} state_t;

  state_t           state, state_nx;
  logic [IN_W-1:0]  hold_code, hold_code_nx;
  logic [DW_W-1:0]  dwell_cnt, dwell_nx;
  logic [IDX_W-1:0] scan_idx_nx;
  logic [OUT_N-1:0] dec_n_nx;
  logic             out_valid_nx, err_nx;
  logic [ERR_W-1:0] err_cnt_nx;
  logic             xfer, code_ok;

  assign in_ready = !rst && !mode && (state != S_SCAN);
  assign xfer     = in_valid && in_ready;
  assign code_ok  = {1'b0, in_code} < OUT_N_C;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_HOLD: begin
        if (mode)      state_nx = S_SCAN;
        else if (xfer) state_nx = code_ok ? S_HOLD : S_IDLE;
      end
      S_SCAN:  if (!mode) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    hold_code_nx = hold_code;
    dwell_nx     = '0;
    scan_idx_nx  = '0;
    err_nx       = 1'b0;
    err_cnt_nx   = err_cnt;
    dec_n_nx     = '1;
    out_valid_nx = 1'b0;

    if (xfer) begin
      if (code_ok) begin
        hold_code_nx = in_code;
      end else begin
        err_nx = 1'b1;
        if (err_cnt != '1) err_cnt_nx = err_cnt + 1'b1;
      end
    end

    // Counters reset to zero on scan entry and exit; they only run while staying in SCAN.
    if (state == S_SCAN && state_nx == S_SCAN) begin
      if (dwell_cnt == DW_LAST) begin
        dwell_nx    = '0;
        scan_idx_nx = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
        dwell_nx    = dwell_cnt + 1'b1;
        scan_idx_nx = scan_idx;
      end
    end

    if (!blank) begin
      case (state_nx)
        S_HOLD: begin
          dec_n_nx     = ~(ONE << hold_code_nx);
          out_valid_nx = 1'b1;
        end
        S_SCAN: begin
          dec_n_nx     = ~(ONE << scan_idx_nx);
          out_valid_nx = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_code <= '0;
      dwell_cnt <= '0;
      scan_idx  <= '0;
      dec_n     <= '1;
      out_valid <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      hold_code <= hold_code_nx;
      dwell_cnt <= dwell_nx;
      scan_idx  <= scan_idx_nx;
      dec_n     <= dec_n_nx;
      out_valid <= out_valid_nx;
      err       <= err_nx;
      err_cnt   <= err_cnt_nx;
    end
  end

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Self-checking bench: two decoder instances (default, and ERR_W=2/DWELL=1) share stimulus
// and are compared every cycle against a behavioural model of the decode/scan rules.
module tb_bcd_scan_decoder;

  logic       clk = 1'b0;
  logic       rst, in_valid, mode, blank;
  logic [3:0] in_code;

  logic       rdy_a, ov_a, err_a;
  logic [9:0] dec_a;
  logic [7:0] ecnt_a;
  logic [3:0] idx_a;

  logic       rdy_b, ov_b, err_b;
  logic [9:0] dec_b;
  logic [1:0] ecnt_b;
  logic [3:0] idx_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_scan_decoder u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_code(in_code),
    .mode(mode), .blank(blank), .dec_n(dec_a), .out_valid(ov_a), .err(err_a),
    .err_cnt(ecnt_a), .scan_idx(idx_a)
  );

  bcd_scan_decoder #(.IN_W(4), .OUT_N(10), .DWELL(1), .ERR_W(2)) u_fast (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_code(in_code),
    .mode(mode), .blank(blank), .dec_n(dec_b), .out_valid(ov_b), .err(err_b),
    .err_cnt(ecnt_b), .scan_idx(idx_b)
  );

  // Model: which line is shown (-1 none), whether scanning and for how long, error totals.
  int hold_line  = -1;
  bit scanning   = 0;
  int scan_cyc   = 0;
  int err_total  = 0;
  bit err_pulse  = 0;
  bit blank_q    = 0;

  function automatic void model_update();
    if (rst) begin
      hold_line = -1; scanning = 0; scan_cyc = 0;
      err_total = 0;  err_pulse = 0; blank_q = 0;
      return;
    end
    err_pulse = 0;
    if (scanning) begin
      if (!mode) begin scanning = 0; hold_line = -1; end
      else scan_cyc++;
    end else if (mode) begin
      scanning = 1; scan_cyc = 0; hold_line = -1;
    end else if (in_valid) begin
      if (int'(in_code) < 10) hold_line = int'(in_code);
      else begin hold_line = -1; err_pulse = 1; err_total++; end
    end
    blank_q = blank;
  endfunction

  function automatic int exp_idx(int dw);
    return scanning ? (scan_cyc / dw) % 10 : 0;
  endfunction

  function automatic logic [9:0] exp_dec(int dw);
    logic [9:0] v;
    int ln;
    v = '1;
    ln = scanning ? exp_idx(dw) : hold_line;
    if (!blank_q && ln >= 0) v[ln] = 1'b0;
    return v;
  endfunction

  function automatic bit exp_ov();
    return !blank_q && (scanning || hold_line >= 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic rdy_exp;
    rdy_exp = !rst && !mode && !scanning;
    chk("a.dec_n",     32'(dec_a),  32'(exp_dec(3)));
    chk("a.out_valid", 32'(ov_a),   32'(exp_ov()));
    chk("a.err",       32'(err_a),  32'(err_pulse));
    chk("a.err_cnt",   32'(ecnt_a), 32'((err_total > 255) ? 255 : err_total));
    chk("a.scan_idx",  32'(idx_a),  32'(exp_idx(3)));
    chk("a.in_ready",  32'(rdy_a),  32'(rdy_exp));
    chk("b.dec_n",     32'(dec_b),  32'(exp_dec(1)));
    chk("b.out_valid", 32'(ov_b),   32'(exp_ov()));
    chk("b.err",       32'(err_b),  32'(err_pulse));
    chk("b.err_cnt",   32'(ecnt_b), 32'((err_total > 3) ? 3 : err_total));
    chk("b.scan_idx",  32'(idx_b),  32'(exp_idx(1)));
    chk("b.in_ready",  32'(rdy_b),  32'(rdy_exp));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic drive(input bit r, input bit v, input int code, input bit md, input bit bl);
    rst = r; in_valid = v; in_code = code[3:0]; mode = md; blank = bl;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_code = '0; mode = 1'b0; blank = 1'b0;
    #2;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // back-to-back in-range codes
    for (int c = 0; c < 10; c++) drive(0, 1, c, 0, 0);
    drive(0, 0, 0, 0, 0);

    // errors from HOLD(5), then enough errors to saturate the narrow counter
    drive(0, 1, 5, 0, 0);
    drive(0, 1, 12, 0, 0);
    drive(0, 1, 15, 0, 0);
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) drive(0, 1, 10 + k, 0, 0);
    drive(0, 0, 0, 0, 0);

    // full scan with wrap, in_valid offered throughout
    drive(0, 1, 2, 0, 0);
    for (int k = 0; k < 36; k++) drive(0, 1, $urandom_range(0, 15), 1, 0);

    // exit mid-scan at index 4 (DWELL=3), then code 7
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    for (int k = 0; k < 12; k++) drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 7, 0, 0);
    drive(0, 0, 0, 0, 0);

    // code accepted under blank shows once blank falls
    drive(0, 1, 3, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // blank during scan keeps the counters running
    drive(0, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++) drive(0, 0, 0, 1, (k >= 2 && k < 5));

    // reset mid-scan
    drive(1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);

    // reset in HOLD with five errors counted
    for (int k = 0; k < 5; k++) drive(0, 1, 11, 0, 0);
    drive(0, 1, 6, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // randomized traffic
    begin
      bit md = 0;
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, 11) == 0) md = ~md;
        drive($urandom_range(0, 59) == 0, $urandom_range(0, 1), $urandom_range(0, 15),
              md, $urandom_range(0, 5) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
